// File: rtl/calc_scheduler.sv
// Round-robin scheduler that shares one calculation core between N_REQ requesters, tags each
// result with the requester id and aborts stalled calculations with a cycle-count watchdog.
module calc_scheduler #(
  parameter int unsigned N_REQ   = 2,
  parameter int unsigned DW      = 32,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic                                         clk_i,
  input  logic                                         rst_ni,
  input  logic [N_REQ-1:0]                             req_valid_i,
  input  logic [N_REQ*DW-1:0]                          req_a0_i,
  input  logic [N_REQ*DW-1:0]                          req_a1_i,
  output logic [N_REQ-1:0]                             req_ready_o,
  output logic [DW-1:0]                                core_a0_o,
  output logic [DW-1:0]                                core_a1_o,
  output logic                                         core_start_o,
  input  logic                                         core_busy_i,
  input  logic [DW-1:0]                                core_result_i,
  output logic                                         resp_valid_o,
  output logic [((N_REQ > 1) ? $clog2(N_REQ) : 1)-1:0] resp_id_o,
  output logic [DW-1:0]                                resp_data_o,
  output logic                                         resp_timeout_o,
  output logic                                         sched_busy_o
);

  localparam int unsigned IDW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int unsigned CW  = $clog2(TIMEOUT + 1);

  localparam logic [2:0] StIdle    = 3'd0;
  localparam logic [2:0] StLaunch  = 3'd1;
  localparam logic [2:0] StWaitAck = 3'd2;
  localparam logic [2:0] StRun     = 3'd3;
  localparam logic [2:0] StDrain   = 3'd4;

  logic [2:0]       state_q, state_d;
  logic [IDW-1:0]   last_q, last_d;
  logic [IDW-1:0]   cur_id_q, cur_id_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [DW-1:0]    core_a0_q, core_a0_d;
  logic [DW-1:0]    core_a1_q, core_a1_d;
  logic             core_start_q, core_start_d;
  logic [N_REQ-1:0] req_ready_q, req_ready_d;
  logic             resp_valid_q, resp_valid_d;
  logic [IDW-1:0]   resp_id_q, resp_id_d;
  logic [DW-1:0]    resp_data_q, resp_data_d;
  logic             resp_timeout_q, resp_timeout_d;
  logic             sched_busy_q, sched_busy_d;

  // Round-robin search: lowest requester above last_q wins, else the lowest requester overall.
  logic             hi_found, lo_found, grant_found;
  logic [IDW-1:0]   hi_idx, lo_idx, grant_idx;
  logic [N_REQ-1:0] grant_oh;
  logic [DW-1:0]    grant_a0, grant_a1;

  always_comb begin
    hi_found = 1'b0;
    lo_found = 1'b0;
    hi_idx   = '0;
    lo_idx   = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (req_valid_i[i]) begin
        if (IDW'(i) > last_q) begin
          hi_found = 1'b1;
          hi_idx   = IDW'(i);
        end
        lo_found = 1'b1;
        lo_idx   = IDW'(i);
      end
    end
  end

  assign grant_found = hi_found | lo_found;
  assign grant_idx   = hi_found ? hi_idx : lo_idx;

  always_comb begin
    grant_oh = '0;
    grant_a0 = '0;
    grant_a1 = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (grant_idx == IDW'(i)) begin
        grant_oh[i] = 1'b1;
        grant_a0    = req_a0_i[i*DW +: DW];
        grant_a1    = req_a1_i[i*DW +: DW];
      end
    end
  end

  // Watchdog counter saturates at TIMEOUT instead of wrapping.
  logic [CW-1:0] cnt_inc;
  logic          cnt_limit;

  assign cnt_inc   = (cnt_q >= CW'(TIMEOUT)) ? CW'(TIMEOUT) : cnt_q + CW'(1);
  assign cnt_limit = (cnt_inc == CW'(TIMEOUT));

  always_comb begin
    state_d        = state_q;
    last_d         = last_q;
    cur_id_d       = cur_id_q;
    cnt_d          = cnt_q;
    core_a0_d      = core_a0_q;
    core_a1_d      = core_a1_q;
    core_start_d   = 1'b0;
    req_ready_d    = '0;
    resp_valid_d   = 1'b0;
    resp_id_d      = resp_id_q;
    resp_data_d    = resp_data_q;
    resp_timeout_d = resp_timeout_q;

    unique case (state_q)
      StIdle: begin
        // Stale core activity blocks any grant until the core is idle.
        if (!core_busy_i && grant_found) begin
          req_ready_d = grant_oh;
          core_a0_d   = grant_a0;
          core_a1_d   = grant_a1;
          cur_id_d    = grant_idx;
          last_d      = grant_idx;
          state_d     = StLaunch;
        end
      end
      StLaunch: begin
        core_start_d = 1'b1;
        cnt_d        = '0;
        state_d      = StWaitAck;
      end
      StWaitAck: begin
        cnt_d = cnt_inc;
        if (core_busy_i) begin
          state_d = StRun;
        end else if (cnt_limit) begin
          resp_valid_d   = 1'b1;
          resp_timeout_d = 1'b1;
          resp_data_d    = '0;
          resp_id_d      = cur_id_q;
          state_d        = StDrain;
        end
      end
      StRun: begin
        cnt_d = cnt_inc;
        // Completion wins over a watchdog expiry on the same edge.
        if (!core_busy_i) begin
          resp_valid_d   = 1'b1;
          resp_timeout_d = 1'b0;
          resp_data_d    = core_result_i;
          resp_id_d      = cur_id_q;
          state_d        = StIdle;
        end else if (cnt_limit) begin
          resp_valid_d   = 1'b1;
          resp_timeout_d = 1'b1;
          resp_data_d    = '0;
          resp_id_d      = cur_id_q;
          state_d        = StDrain;
        end
      end
      StDrain: begin
        if (!core_busy_i) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    sched_busy_d = (state_d != StIdle);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q        <= StIdle;
      last_q         <= IDW'(N_REQ - 1);
      cur_id_q       <= '0;
      cnt_q          <= '0;
      core_a0_q      <= '0;
      core_a1_q      <= '0;
      core_start_q   <= 1'b0;
      req_ready_q    <= '0;
      resp_valid_q   <= 1'b0;
      resp_id_q      <= '0;
      resp_data_q    <= '0;
      resp_timeout_q <= 1'b0;
      sched_busy_q   <= 1'b0;
    end else begin
      state_q        <= state_d;
      last_q         <= last_d;
      cur_id_q       <= cur_id_d;
      cnt_q          <= cnt_d;
      core_a0_q      <= core_a0_d;
      core_a1_q      <= core_a1_d;
      core_start_q   <= core_start_d;
      req_ready_q    <= req_ready_d;
      resp_valid_q   <= resp_valid_d;
      resp_id_q      <= resp_id_d;
      resp_data_q    <= resp_data_d;
      resp_timeout_q <= resp_timeout_d;
      sched_busy_q   <= sched_busy_d;
    end
  end

  assign req_ready_o    = req_ready_q;
  assign core_a0_o      = core_a0_q;
  assign core_a1_o      = core_a1_q;
  assign core_start_o   = core_start_q;
  assign resp_valid_o   = resp_valid_q;
  assign resp_id_o      = resp_id_q;
  assign resp_data_o    = resp_data_q;
  assign resp_timeout_o = resp_timeout_q;
  assign sched_busy_o   = sched_busy_q;

endmodule
